llc_vict_buff: RTL and testbench
================================

LLC_VICT_BUFF -- requirements
Module: llc_vict_buff

Interface
REQ-001 SHALL take parameter LLC_ADDR_WIDTH, default llc_config_pkg value: victim line address width.
REQ-002 SHALL take parameter DATA_W, default 512: cache-line data width, equal to DAT_DATA_WIDTH.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 vict_i  in  vict_info_t  eviction from the LLC pipeline: valid, clean, addr.
REQ-006 vict_data_i  in  DATA_W  victim line data, qualified by vict_i.valid.
REQ-007 vict_ready_o  out  1  buffer can accept a victim.
REQ-008 rsp2vb_i  in  rsp2vb_info_t  decoded RSP-channel events: dbid, dbid_v, snprsp_v.
REQ-009 snp_dat_v_i / snp_dat_i  in  1 / DATA_W  SnpRespData for the held line.
REQ-010 snp_valid_o / snp_ready_i  out / in  1 / 1  snoop-channel handshake.
REQ-011 snp_addr_o  out  SNP_ADDR_WIDTH  = held addr[ADDR_W-1:3]; snp_tgt_o = RN_MSK_SNP; snp_txnid_o = LLC_VictBuff_ID.
REQ-012 req_valid_o / req_ready_i  out / in  1 / 1  request-channel handshake to SN.
REQ-013 req_opcode_o  out  request_opcode_e  WriteBackFull; req_addr_o = held addr; req_tgt_o = SN_ID; req_txnid_o = LLC_VictBuff_ID.
REQ-014 dat_valid_o / dat_ready_i  out / in  1 / 1  write-data handshake; dat_txnid_o = held dbid, dat_data_o = held data.
REQ-015 lookup_addr_i  in  LLC_ADDR_WIDTH; conflict_o  out  1  address-hazard check for the request pipeline.
REQ-016 vb_info_o  out  vict_buff_info_t  live valid/state/dbid/addr/clean.

Function
REQ-017 SHALL implement vict_buff_state_t FSM: RESET, EMPTY, WAIT_SNP_RSP, WAIT_DBID, WRITEBACK.
REQ-018 RESET -> EMPTY unconditionally after one cycle; vict_ready_o=0 in RESET.
REQ-019 vict_ready_o SHALL be 1 exactly when state==EMPTY (registered state, no combinational path from vict_i).
REQ-020 EMPTY with vict_i.valid: capture zero_offset_addr(addr), clean, data; go to WAIT_SNP_RSP next cycle.
REQ-021 WAIT_SNP_RSP: snp_valid_o held high, fields stable, until snp_ready_i; then low until response.
REQ-022 snp_dat_v_i in WAIT_SNP_RSP (after snoop sent) SHALL overwrite data, set clean=0, and end the snoop phase.
REQ-023 snprsp_v in WAIT_SNP_RSP ends the snoop phase; if snprsp_v and snp_dat_v_i coincide, the data path wins.
REQ-024 End of snoop phase: clean -> EMPTY (silent drop, no request); dirty -> WAIT_DBID.
REQ-025 WAIT_DBID: req_valid_o held high until req_ready_i; dbid_v accepted only after that handshake; captures dbid -> WRITEBACK.
REQ-026 WRITEBACK: dat_valid_o high until dat_ready_i; then EMPTY next cycle.
REQ-027 dbid_v, snprsp_v, snp_dat_v_i SHALL be ignored in any state not expecting them.
REQ-028 conflict_o combinational = vb_info_o.valid && zero_offset_addr(lookup_addr_i)==held addr.
REQ-029 vb_info_o.valid SHALL be 1 in WAIT_SNP_RSP, WAIT_DBID, WRITEBACK, else 0.
REQ-030 Minimum latency: dirty victim with zero-wait handshakes returns to EMPTY 4 cycles after response/dbid arrivals chain (accept, snoop, req, data), one state per cycle.

Reset
REQ-031 rst_n=0 at any clock edge, including mid-operation: state=RESET, valid=0, dbid=0, addr=0, clean=0, internal sent-flags=0.
REQ-032 During and one cycle after reset, all *_valid_o, vict_ready_o, conflict_o SHALL be 0; in-flight transaction is abandoned.

Structure
REQ-033 vict_info_t, vict_buff_info_t, vict_buff_state_t, rsp2vb_info_t, zero_offset_addr, node IDs and LLC_VictBuff_ID SHALL come from llc_common_pkg; no local redefinitions.
REQ-034 Single flat module; no sub-module; data register is one DATA_W flop bank.

Verification
REQ-035 Clean victim 0x1040, snprsp_v -> snp_addr_o=0x208, return to EMPTY, req_valid_o never asserted.
REQ-036 Dirty victim 0x2000, data all 0xA5; snprsp; dbid_v dbid=5 -> req txnid 129 tgt 64 WriteBackFull, then dat_txnid_o=5, data 0xA5..; vict_ready_o=1 after dat_ready_i.
REQ-037 Clean victim 0x3000, snp_dat_v_i with 0x5A.. -> WriteBackFull issued, written data 0x5A.., vb_info_o.clean=0.
REQ-038 req_ready_i low 10 cycles, dbid_v pulsed in WAIT_SNP_RSP -> req fields stable, early dbid ignored, state unchanged.
REQ-039 rst_n low for one cycle during WRITEBACK -> next cycle all valids 0, state RESET, then EMPTY.
REQ-040 Held 0x2000, lookup 0x2010 -> conflict_o=1; lookup 0x2040 -> 0; after return to EMPTY, lookup 0x2000 -> 0.

Source files
------------

// File: rtl/llc_common_pkg.sv
// Shared LLC types, node IDs and helpers for the victim buffer.
// Exports vict/rsp/buffer-info structs, FSM states and zero_offset_addr.
package llc_common_pkg;
    import llc_config_pkg::*;

    localparam int LLC_ADDR_W     = LLC_ADDR_WIDTH_CFG;
    localparam int SNP_ADDR_WIDTH = LLC_ADDR_W - 3;
    localparam int LINE_OFFS_W    = 6;
    localparam int NODE_ID_W      = 7;
    localparam int TXNID_W        = 8;
    localparam int DBID_W         = 8;
    localparam int RN_MSK_W       = 4;

    localparam logic [NODE_ID_W-1:0] SN_ID           = 7'd64;
    localparam logic [RN_MSK_W-1:0]  RN_MSK_SNP      = 4'hF;
    localparam logic [TXNID_W-1:0]   LLC_VictBuff_ID = 8'd129;

    typedef enum logic [6:0] {
        REQ_READSHARED    = 7'h01,
        REQ_READUNIQUE    = 7'h07,
        REQ_WRITEBACKFULL = 7'h1B
    } request_opcode_e;

    typedef enum logic [2:0] {
        VB_RESET        = 3'd0,
        VB_EMPTY        = 3'd1,
        VB_WAIT_SNP_RSP = 3'd2,
        VB_WAIT_DBID    = 3'd3,
        VB_WRITEBACK    = 3'd4
    } vict_buff_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  clean;
        logic [LLC_ADDR_W-1:0] addr;
    } vict_info_t;

    typedef struct packed {
        logic [DBID_W-1:0] dbid;
        logic              dbid_v;
        logic              snprsp_v;
    } rsp2vb_info_t;

    typedef struct packed {
        logic                  valid;
        vict_buff_state_t      state;
        logic [DBID_W-1:0]     dbid;
        logic [LLC_ADDR_W-1:0] addr;
        logic                  clean;
    } vict_buff_info_t;

    function automatic logic [LLC_ADDR_W-1:0] zero_offset_addr(
        input logic [LLC_ADDR_W-1:0] a
    );
        return {a[LLC_ADDR_W-1:LINE_OFFS_W], {LINE_OFFS_W{1'b0}}};
    endfunction
endpackage

// File: rtl/llc_config_pkg.sv
// LLC build-time configuration shared by all LLC blocks.
// Holds address and data-path widths only.
package llc_config_pkg;
    localparam int LLC_ADDR_WIDTH_CFG = 44;
    localparam int DAT_DATA_WIDTH     = 512;
endpackage

// File: rtl/llc_vict_buff_if.sv
// Snoop, request and write-data channels of the LLC victim buffer.
// master = victim buffer (drives valids/payload), slave = fabric side.
interface llc_vict_buff_if #(
    parameter int DATA_W = 512
);
    import llc_common_pkg::*;

    logic                      snp_valid_o;
    logic                      snp_ready_i;
    logic [SNP_ADDR_WIDTH-1:0] snp_addr_o;
    logic [RN_MSK_W-1:0]       snp_tgt_o;
    logic [TXNID_W-1:0]        snp_txnid_o;

    logic                      req_valid_o;
    logic                      req_ready_i;
    request_opcode_e           req_opcode_o;
    logic [LLC_ADDR_W-1:0]     req_addr_o;
    logic [NODE_ID_W-1:0]      req_tgt_o;
    logic [TXNID_W-1:0]        req_txnid_o;

    logic                      dat_valid_o;
    logic                      dat_ready_i;
    logic [DBID_W-1:0]         dat_txnid_o;
    logic [DATA_W-1:0]         dat_data_o;

    modport master (
        output snp_valid_o, snp_addr_o, snp_tgt_o, snp_txnid_o,
        input  snp_ready_i,
        output req_valid_o, req_opcode_o, req_addr_o, req_tgt_o,
        output req_txnid_o,
        input  req_ready_i,
        output dat_valid_o, dat_txnid_o, dat_data_o,
        input  dat_ready_i
    );

    modport slave (
        input  snp_valid_o, snp_addr_o, snp_tgt_o, snp_txnid_o,
        output snp_ready_i,
        input  req_valid_o, req_opcode_o, req_addr_o, req_tgt_o,
        input  req_txnid_o,
        output req_ready_i,
        input  dat_valid_o, dat_txnid_o, dat_data_o,
        output dat_ready_i
    );
endinterface

// File: rtl/llc_vict_buff.sv
// Single-entry LLC victim buffer: snoops the evicted line, drops it if
// clean, else writes it back to SN. Ports: clk, rst_n (sync, low),
// vict_i/vict_data_i/vict_ready_o, rsp2vb_i, snp_dat_v_i/snp_dat_i,
// lookup_addr_i/conflict_o, vb_info_o, bus (snp/req/dat channels).
module llc_vict_buff
    import llc_config_pkg::*;
    import llc_common_pkg::*;
#(
    parameter int LLC_ADDR_WIDTH = LLC_ADDR_WIDTH_CFG,
    parameter int DATA_W         = DAT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  vict_info_t                vict_i,
    input  logic [DATA_W-1:0]         vict_data_i,
    output logic                      vict_ready_o,
    input  rsp2vb_info_t              rsp2vb_i,
    input  logic                      snp_dat_v_i,
    input  logic [DATA_W-1:0]         snp_dat_i,
    input  logic [LLC_ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                      conflict_o,
    output vict_buff_info_t           vb_info_o,
    llc_vict_buff_if.master           bus
);
    vict_buff_state_t      state_q;
    logic [LLC_ADDR_W-1:0] addr_q;
    logic [DBID_W-1:0]     dbid_q;
    logic                  clean_q;
    logic [DATA_W-1:0]     data_q;
    logic                  snp_valid_q;
    logic                  snp_sent_q;
    logic                  req_valid_q;
    logic                  req_sent_q;
    logic                  dat_valid_q;
    logic                  busy;
    logic                  snp_end;

    // Responses only count once the snoop has actually left.
    assign snp_end = snp_sent_q && (snp_dat_v_i || rsp2vb_i.snprsp_v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= VB_RESET;
            addr_q      <= '0;
            dbid_q      <= '0;
            clean_q     <= 1'b0;
            data_q      <= '0;
            snp_valid_q <= 1'b0;
            snp_sent_q  <= 1'b0;
            req_valid_q <= 1'b0;
            req_sent_q  <= 1'b0;
            dat_valid_q <= 1'b0;
        end else begin
            case (state_q)
                VB_RESET: state_q <= VB_EMPTY;
                VB_EMPTY: begin
                    if (vict_i.valid) begin
                        addr_q      <= zero_offset_addr(vict_i.addr);
                        clean_q     <= vict_i.clean;
                        data_q      <= vict_data_i;
                        snp_valid_q <= 1'b1;
                        snp_sent_q  <= 1'b0;
                        state_q     <= VB_WAIT_SNP_RSP;
                    end
                end
                VB_WAIT_SNP_RSP: begin
                    if (snp_valid_q && bus.snp_ready_i) begin
                        snp_valid_q <= 1'b0;
                        snp_sent_q  <= 1'b1;
                    end
                    if (snp_end) begin
                        snp_sent_q <= 1'b0;
                        // Snooped data is always newer and makes the line dirty.
                        if (snp_dat_v_i) begin
                            data_q  <= snp_dat_i;
                            clean_q <= 1'b0;
                        end
                        if (clean_q && !snp_dat_v_i) begin
                            state_q <= VB_EMPTY;
                        end else begin
                            req_valid_q <= 1'b1;
                            req_sent_q  <= 1'b0;
                            state_q     <= VB_WAIT_DBID;
                        end
                    end
                end
                VB_WAIT_DBID: begin
                    if (req_valid_q && bus.req_ready_i) begin
                        req_valid_q <= 1'b0;
                        req_sent_q  <= 1'b1;
                    end
                    if (req_sent_q && rsp2vb_i.dbid_v) begin
                        dbid_q      <= rsp2vb_i.dbid;
                        req_sent_q  <= 1'b0;
                        dat_valid_q <= 1'b1;
                        state_q     <= VB_WRITEBACK;
                    end
                end
                VB_WRITEBACK: begin
                    if (bus.dat_ready_i) begin
                        dat_valid_q <= 1'b0;
                        state_q     <= VB_EMPTY;
                    end
                end
                default: state_q <= VB_RESET;
            endcase
        end
    end

    assign busy = (state_q == VB_WAIT_SNP_RSP) ||
                  (state_q == VB_WAIT_DBID) ||
                  (state_q == VB_WRITEBACK);

    assign vict_ready_o = (state_q == VB_EMPTY);
    assign conflict_o   = busy &&
        (zero_offset_addr(LLC_ADDR_W'(lookup_addr_i)) == addr_q);

    always_comb begin
        vb_info_o       = '0;
        vb_info_o.valid = busy;
        vb_info_o.state = state_q;
        vb_info_o.dbid  = dbid_q;
        vb_info_o.addr  = addr_q;
        vb_info_o.clean = clean_q;
    end

    assign bus.snp_valid_o  = snp_valid_q;
    assign bus.snp_addr_o   = addr_q[LLC_ADDR_W-1:3];
    assign bus.snp_tgt_o    = RN_MSK_SNP;
    assign bus.snp_txnid_o  = LLC_VictBuff_ID;
    assign bus.req_valid_o  = req_valid_q;
    assign bus.req_opcode_o = REQ_WRITEBACKFULL;
    assign bus.req_addr_o   = addr_q;
    assign bus.req_tgt_o    = SN_ID;
    assign bus.req_txnid_o  = LLC_VictBuff_ID;
    assign bus.dat_valid_o  = dat_valid_q;
    assign bus.dat_txnid_o  = dbid_q;
    assign bus.dat_data_o   = data_q;
endmodule

// File: tb/tb_llc_vict_buff.sv
// Self-checking bench for llc_vict_buff: directed scenarios plus
// randomized victims compared against a transaction-level model.
module tb_llc_vict_buff;
    import llc_common_pkg::*;

    localparam int AW = LLC_ADDR_W;
    localparam int DW = 512;
    localparam logic [AW-1:0] LINE_B = 64;
    localparam logic [AW-1:0] EIGHT  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    vict_info_t      vict;
    logic [DW-1:0]   vict_data;
    logic            vict_ready;
    rsp2vb_info_t    rsp;
    logic            snp_dat_v;
    logic [DW-1:0]   snp_dat;
    logic [AW-1:0]   lookup;
    logic            conflict;
    vict_buff_info_t vb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    llc_vict_buff_if #(.DATA_W(DW)) bus ();

    llc_vict_buff #(.LLC_ADDR_WIDTH(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vict_i       (vict),
        .vict_data_i  (vict_data),
        .vict_ready_o (vict_ready),
        .rsp2vb_i     (rsp),
        .snp_dat_v_i  (snp_dat_v),
        .snp_dat_i    (snp_dat),
        .lookup_addr_i(lookup),
        .conflict_o   (conflict),
        .vb_info_o    (vb),
        .bus          (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vict = '0; vict_data = '0; rsp = '0;
        snp_dat_v = 1'b0; snp_dat = '0; lookup = '0;
        bus.snp_ready_i = 1'b0;
        bus.req_ready_i = 1'b0;
        bus.dat_ready_i = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic accept(input logic [AW-1:0] a, input logic c,
                          input logic [DW-1:0] d);
        vict.valid = 1'b1; vict.clean = c; vict.addr = a; vict_data = d;
        step();
        vict = '0; vict_data = '0;
    endtask

    task automatic snoop_hs();
        bus.snp_ready_i = 1'b1; step(); bus.snp_ready_i = 1'b0;
    endtask

    task automatic req_hs();
        bus.req_ready_i = 1'b1; step(); bus.req_ready_i = 1'b0;
    endtask

    task automatic dat_hs();
        bus.dat_ready_i = 1'b1; step(); bus.dat_ready_i = 1'b0;
    endtask

    task automatic pulse_rsp(input logic sr, input logic sd,
                             input logic [DW-1:0] d);
        rsp.snprsp_v = sr; snp_dat_v = sd; snp_dat = d;
        step();
        rsp.snprsp_v = 1'b0; snp_dat_v = 1'b0; snp_dat = '0;
    endtask

    task automatic pulse_dbid(input logic [DBID_W-1:0] id);
        rsp.dbid_v = 1'b1; rsp.dbid = id;
        step();
        rsp.dbid_v = 1'b0; rsp.dbid = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step(); step();
        checks++; if (vb.state !== VB_RESET) begin errors++;
            $display("FAIL rst_state got %0d exp %0d", vb.state, VB_RESET); end
        checks++; if (vict_ready !== 1'b0) begin errors++;
            $display("FAIL rst_ready got %b exp 0", vict_ready); end
        checks++; if ({bus.snp_valid_o, bus.req_valid_o, bus.dat_valid_o} !== 3'b000) begin errors++;
            $display("FAIL rst_valids got %b%b%b exp 000", bus.snp_valid_o, bus.req_valid_o, bus.dat_valid_o); end
        checks++; if ({vb.valid, vb.clean, vb.dbid, vb.addr} !== '0) begin errors++;
            $display("FAIL rst_info got v%b c%b d%h a%h exp 0", vb.valid, vb.clean, vb.dbid, vb.addr); end
        checks++; if (conflict !== 1'b0) begin errors++;
            $display("FAIL rst_conflict got %b exp 0", conflict); end
        rst_n = 1'b1;
        step();
        checks++; if (vb.state !== VB_EMPTY || vict_ready !== 1'b1) begin errors++;
            $display("FAIL rst_exit got st%0d rdy%b exp st%0d rdy1", vb.state, vict_ready, VB_EMPTY); end
    endtask

    task automatic test_clean_drop();
        logic seen_req;
        accept(44'h1040, 1'b1, rand_data());
        seen_req = bus.req_valid_o;
        checks++; if (vb.state !== VB_WAIT_SNP_RSP || vict_ready !== 1'b0 || vb.valid !== 1'b1) begin errors++;
            $display("FAIL clean_accept got st%0d rdy%b v%b", vb.state, vict_ready, vb.valid); end
        checks++; if (bus.snp_valid_o !== 1'b1 || bus.snp_addr_o !== SNP_ADDR_WIDTH'(41'h208)) begin errors++;
            $display("FAIL clean_snp got v%b a%h exp v1 a208", bus.snp_valid_o, bus.snp_addr_o); end
        checks++; if (bus.snp_tgt_o !== 4'hF || bus.snp_txnid_o !== 8'd129) begin errors++;
            $display("FAIL clean_snp_ids got t%h x%0d exp tF x129", bus.snp_tgt_o, bus.snp_txnid_o); end
        snoop_hs();
        seen_req |= bus.req_valid_o;
        checks++; if (bus.snp_valid_o !== 1'b0) begin errors++;
            $display("FAIL clean_snp_drop got %b exp 0", bus.snp_valid_o); end
        pulse_rsp(1'b1, 1'b0, '0);
        seen_req |= bus.req_valid_o;
        step();
        seen_req |= bus.req_valid_o;
        checks++; if (vb.state !== VB_EMPTY || vict_ready !== 1'b1) begin errors++;
            $display("FAIL clean_end got st%0d rdy%b exp st%0d rdy1", vb.state, vict_ready, VB_EMPTY); end
        checks++; if (seen_req !== 1'b0) begin errors++;
            $display("FAIL clean_noreq got %b exp 0", seen_req); end
    endtask

    task automatic test_dirty_wb();
        logic [DW-1:0] d;
        d = {64{8'hA5}};
        accept(44'h2000, 1'b0, d);
        snoop_hs();
        pulse_rsp(1'b1, 1'b0, '0);
        checks++; if (vb.state !== VB_WAIT_DBID || bus.req_valid_o !== 1'b1) begin errors++;
            $display("FAIL dirty_req got st%0d v%b", vb.state, bus.req_valid_o); end
        checks++; if (bus.req_opcode_o !== REQ_WRITEBACKFULL || bus.req_addr_o !== 44'h2000) begin errors++;
            $display("FAIL dirty_req_f got op%h a%h exp op1b a2000", bus.req_opcode_o, bus.req_addr_o); end
        checks++; if (bus.req_txnid_o !== 8'd129 || bus.req_tgt_o !== 7'd64) begin errors++;
            $display("FAIL dirty_req_ids got x%0d t%0d exp x129 t64", bus.req_txnid_o, bus.req_tgt_o); end
        req_hs();
        checks++; if (bus.req_valid_o !== 1'b0) begin errors++;
            $display("FAIL dirty_req_drop got %b exp 0", bus.req_valid_o); end
        pulse_dbid(8'd5);
        checks++; if (vb.state !== VB_WRITEBACK || bus.dat_valid_o !== 1'b1 || bus.dat_txnid_o !== 8'd5) begin errors++;
            $display("FAIL dirty_dat got st%0d v%b x%0d exp x5", vb.state, bus.dat_valid_o, bus.dat_txnid_o); end
        checks++; if (bus.dat_data_o !== d) begin errors++;
            $display("FAIL dirty_data got %h exp %h", bus.dat_data_o, d); end
        dat_hs();
        checks++; if (vict_ready !== 1'b1 || bus.dat_valid_o !== 1'b0) begin errors++;
            $display("FAIL dirty_end got rdy%b dv%b exp rdy1 dv0", vict_ready, bus.dat_valid_o); end
    endtask

    task automatic test_snp_data();
        logic [DW-1:0] d;
        d = {64{8'h5A}};
        accept(44'h3000, 1'b1, rand_data());
        snoop_hs();
        // data and plain response together: data must win
        pulse_rsp(1'b1, 1'b1, d);
        checks++; if (vb.state !== VB_WAIT_DBID || vb.clean !== 1'b0 || bus.req_valid_o !== 1'b1) begin errors++;
            $display("FAIL snpdat_req got st%0d c%b v%b", vb.state, vb.clean, bus.req_valid_o); end
        req_hs();
        pulse_dbid(8'd9);
        checks++; if (bus.dat_data_o !== d || bus.dat_txnid_o !== 8'd9) begin errors++;
            $display("FAIL snpdat_wb got x%0d %h exp x9 %h", bus.dat_txnid_o, bus.dat_data_o, d); end
        dat_hs();
        checks++; if (vb.state !== VB_EMPTY) begin errors++;
            $display("FAIL snpdat_end got %0d exp %0d", vb.state, VB_EMPTY); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d;
        int bad;
        d = rand_data();
        accept(44'h4080, 1'b0, d);
        pulse_dbid(8'h33);
        checks++; if (vb.state !== VB_WAIT_SNP_RSP || bus.snp_valid_o !== 1'b1) begin errors++;
            $display("FAIL stall_early_dbid got st%0d v%b", vb.state, bus.snp_valid_o); end
        snoop_hs();
        pulse_dbid(8'h34);
        pulse_rsp(1'b0, 1'b0, '0);
        checks++; if (vb.state !== VB_WAIT_SNP_RSP) begin errors++;
            $display("FAIL stall_snp_hold got %0d exp %0d", vb.state, VB_WAIT_SNP_RSP); end
        pulse_rsp(1'b1, 1'b0, '0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) pulse_dbid(8'(i + 1));
            else if (i == 4) pulse_rsp(1'b0, 1'b1, ~d);
            else step();
            if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 44'h4080 ||
                vb.state !== VB_WAIT_DBID || bus.req_opcode_o !== REQ_WRITEBACKFULL)
                bad++;
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL stall_req_stable got %0d bad cycles exp 0", bad); end
        req_hs();
        pulse_dbid(8'h11);
        checks++; if (vb.state !== VB_WRITEBACK || bus.dat_txnid_o !== 8'h11) begin errors++;
            $display("FAIL stall_dbid got st%0d x%h exp x11", vb.state, bus.dat_txnid_o); end
        checks++; if (bus.dat_data_o !== d) begin errors++;
            $display("FAIL stall_data got %h exp %h", bus.dat_data_o, d); end
        dat_hs();
    endtask

    task automatic test_conflict();
        accept(44'h2000, 1'b0, rand_data());
        lookup = 44'h2010; #1;
        checks++; if (conflict !== 1'b1) begin errors++;
            $display("FAIL conf_same got %b exp 1", conflict); end
        lookup = 44'h2040; #1;
        checks++; if (conflict !== 1'b0) begin errors++;
            $display("FAIL conf_next got %b exp 0", conflict); end
        snoop_hs();
        pulse_rsp(1'b1, 1'b0, '0);
        req_hs();
        pulse_dbid(8'd1);
        dat_hs();
        lookup = 44'h2000; #1;
        checks++; if (conflict !== 1'b0) begin errors++;
            $display("FAIL conf_empty got %b exp 0", conflict); end
        lookup = '0;
    endtask

    task automatic test_random();
        logic [AW-1:0] a, line;
        logic [DW-1:0] d, sd, exp_w;
        logic [DBID_W-1:0] id;
        logic c, dirty;
        int kind;
        for (int n = 0; n < 25; n++) begin
            a = AW'({$urandom(), $urandom()});
            line = (a / LINE_B) * LINE_B;
            c = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            d = rand_data();
            sd = rand_data();
            id = 8'($urandom());
            dirty = !c || kind != 0;
            exp_w = (kind != 0) ? sd : d;
            accept(a, c, d);
            checks++; if (vb.addr !== line || vb.clean !== c) begin errors++;
                $display("FAIL rnd%0d_cap got a%h c%b exp a%h c%b", n, vb.addr, vb.clean, line, c); end
            repeat ($urandom_range(0, 3)) step();
            checks++; if (bus.snp_valid_o !== 1'b1 || bus.snp_addr_o !== SNP_ADDR_WIDTH'(line / EIGHT)) begin errors++;
                $display("FAIL rnd%0d_snp got v%b a%h exp v1 a%h", n, bus.snp_valid_o, bus.snp_addr_o, line / EIGHT); end
            lookup = line + AW'($urandom_range(0, 63)); #1;
            checks++; if (conflict !== 1'b1) begin errors++;
                $display("FAIL rnd%0d_conf_hit got %b exp 1", n, conflict); end
            lookup = line ^ (AW'(1) << $urandom_range(6, 30)); #1;
            checks++; if (conflict !== 1'b0) begin errors++;
                $display("FAIL rnd%0d_conf_miss got %b exp 0", n, conflict); end
            lookup = '0;
            snoop_hs();
            repeat ($urandom_range(0, 2)) step();
            pulse_rsp(kind != 1, kind != 0, sd);
            if (!dirty) begin
                checks++; if (vb.state !== VB_EMPTY || bus.req_valid_o !== 1'b0) begin errors++;
                    $display("FAIL rnd%0d_drop got st%0d rv%b", n, vb.state, bus.req_valid_o); end
            end else begin
                checks++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== line) begin errors++;
                    $display("FAIL rnd%0d_req got v%b a%h exp a%h", n, bus.req_valid_o, bus.req_addr_o, line); end
                repeat ($urandom_range(0, 3)) step();
                req_hs();
                repeat ($urandom_range(0, 2)) step();
                pulse_dbid(id);
                repeat ($urandom_range(0, 3)) step();
                checks++; if (bus.dat_valid_o !== 1'b1 || bus.dat_txnid_o !== id || bus.dat_data_o !== exp_w) begin errors++;
                    $display("FAIL rnd%0d_wb got v%b x%h d%h exp x%h d%h", n, bus.dat_valid_o, bus.dat_txnid_o, bus.dat_data_o, id, exp_w); end
                dat_hs();
                checks++; if (vb.state !== VB_EMPTY || vict_ready !== 1'b1) begin errors++;
                    $display("FAIL rnd%0d_end got st%0d rdy%b", n, vb.state, vict_ready); end
            end
        end
    endtask

    task automatic test_reset_mid();
        accept(44'h5000, 1'b0, rand_data());
        snoop_hs();
        pulse_rsp(1'b1, 1'b0, '0);
        req_hs();
        pulse_dbid(8'd2);
        checks++; if (vb.state !== VB_WRITEBACK) begin errors++;
            $display("FAIL midrst_pre got %0d exp %0d", vb.state, VB_WRITEBACK); end
        lookup = 44'h5000;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (vb.state !== VB_RESET || vict_ready !== 1'b0 || conflict !== 1'b0) begin errors++;
            $display("FAIL midrst_state got st%0d rdy%b cf%b", vb.state, vict_ready, conflict); end
        checks++; if ({bus.snp_valid_o, bus.req_valid_o, bus.dat_valid_o, vb.valid} !== 4'b0000) begin errors++;
            $display("FAIL midrst_valids got %b%b%b%b exp 0000", bus.snp_valid_o, bus.req_valid_o, bus.dat_valid_o, vb.valid); end
        checks++; if (vb.addr !== '0 || vb.dbid !== '0) begin errors++;
            $display("FAIL midrst_regs got a%h d%h exp 0", vb.addr, vb.dbid); end
        step();
        checks++; if (vb.state !== VB_EMPTY || vict_ready !== 1'b1 || bus.dat_valid_o !== 1'b0) begin errors++;
            $display("FAIL midrst_exit got st%0d rdy%b dv%b", vb.state, vict_ready, bus.dat_valid_o); end
        lookup = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_drop();
        test_dirty_wb();
        test_snp_data();
        test_stall();
        test_conflict();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
